mem_responder: RTL and testbench

- Memory-side responder for the multicycle CPU's memory port. It is the slave end of the CPU's address/write-enable/data access.
- Accepts one word-sized read or write request at a time over a req/ready handshake and inserts a configurable number of wait states.
- Holds its own word storage and flags misaligned or out-of-range accesses.
- Lets the CPU control FSM be exercised against realistic, non-zero memory latency.

---
 rtl/mem_resp_pkg.sv | 23 ++
 rtl/mem_resp_array.sv | 35 +++
 rtl/mem_responder.sv | 126 ++++++++++++
 tb/tb_mem_responder.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory responder slice.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
// Contents: state enum, word/lane/counter widths, address error check.
package mem_resp_pkg;

  localparam int WORD_W     = 32;
  localparam int BYTE_LANES = 4;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // A byte address is bad if it is not word aligned or if any bit above
  // the word-index field is set (the access would alias into storage).
  function automatic logic addr_err(input logic [WORD_W-1:0] a, input int aw);
    return (a[1:0] != 2'b00) || ((a >> (aw + 2)) != '0);
  endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Single-port word storage with per-lane write enables and a registered read port.
// Latency: read data appears one clock after re; writes land on the same edge.
// Backpressure: none, one access per cycle whenever we/re is asserted.
// Ports: clock; we/re strobes; idx word index; wdata/be write data and lane
//        enables (be[3] = bits 31:24); rdata registered, holds when re=0.
// Storage is never cleared by reset.
module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     idx,
  input  logic [WORD_W-1:0]     wdata,
  input  logic [BYTE_LANES-1:0] be,
  output logic [WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] mem_q [2**ADDR_W];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < BYTE_LANES; i++) begin
        if (be[i]) mem_q[idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (re) rdata_q <= mem_q[idx];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one word read/write at a time with WAIT_STATES wait cycles.
// Latency: req accepted at edge k -> ready high in the cycle after edge k+WAIT_STATES.
// Backpressure: req is only sampled in IDLE; a new request is taken WAIT_STATES+2 cycles apart.
// Ports: clock; reset (sync, active low); req/wr/addr/wdata request (byte address);
//        rdata/ready/err response, err qualified by ready.
// Optional: MEM_RESP_BYTEEN_EN adds a 4-bit be write-lane-enable input.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
`ifdef MEM_RESP_BYTEEN_EN
  input  logic [BYTE_LANES-1:0] be,
`endif
  output logic [WORD_W-1:0] rdata,
  output logic              ready,
  output logic              err
);

  localparam logic [CNT_W-1:0] WS = CNT_W'(WAIT_STATES);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wr_q;
  logic [WORD_W-1:0]  addr_q;
  logic [WORD_W-1:0]  wdata_q;
  logic               ready_q;
  logic               err_q;
  logic               rzero_q;  // response data forced to zero (reset / errored access)

  logic                  commit;
  logic                  cmt_wr;
  logic [WORD_W-1:0]     cmt_addr;
  logic [WORD_W-1:0]     cmt_wdata;
  logic [BYTE_LANES-1:0] cmt_be;
  logic                  cmt_err;
  logic [WORD_W-1:0]     arr_rdata;

`ifdef MEM_RESP_BYTEEN_EN
  logic [BYTE_LANES-1:0] be_q;
`endif

  assign cnt_d = cnt_q - 1'b1;

  // The commit edge is the edge that enters RESP. With zero wait states that
  // is the acceptance edge itself, so the operands come straight from the
  // inputs; otherwise they come from the latched copy.
  assign commit = reset &&
                  (((state_q == IDLE) && req && (WS == '0)) ||
                   ((state_q == WAIT) && (cnt_q == CNT_W'(1))));

  assign cmt_wr    = (state_q == IDLE) ? wr    : wr_q;
  assign cmt_addr  = (state_q == IDLE) ? addr  : addr_q;
  assign cmt_wdata = (state_q == IDLE) ? wdata : wdata_q;
`ifdef MEM_RESP_BYTEEN_EN
  assign cmt_be    = (state_q == IDLE) ? be    : be_q;
`else
  assign cmt_be    = {BYTE_LANES{1'b1}};
`endif
  assign cmt_err   = addr_err(cmt_addr, ADDR_W);

  mem_resp_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clock (clock),
    .we    (commit && cmt_wr && !cmt_err),
    .re    (commit && !cmt_wr && !cmt_err),
    .idx   (cmt_addr[ADDR_W+1:2]),
    .wdata (cmt_wdata),
    .be    (cmt_be),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rzero_q <= 1'b1;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      if (commit) begin
        ready_q <= 1'b1;
        err_q   <= cmt_err;
        // Good writes leave the previous read data visible.
        if (cmt_err)      rzero_q <= 1'b1;
        else if (!cmt_wr) rzero_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (req) begin
            wr_q    <= wr;
            addr_q  <= addr;
            wdata_q <= wdata;
`ifdef MEM_RESP_BYTEEN_EN
            be_q    <= be;
`endif
            cnt_q   <= WS;
            state_q <= (WS == '0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_d;
          if (cnt_q == CNT_W'(1)) state_q <= RESP;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready = ready_q;
  assign err   = err_q;
  assign rdata = rzero_q ? '0 : arr_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances (WAIT_STATES 2, 0, 4).
module tb_mem_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  req, wr, ready, err;
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic [3:0]  be    [3];

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mem_responder #(.ADDR_W(8), .WAIT_STATES(2)) u0 (
    .clock(clock), .reset(reset), .req(req[0]), .wr(wr[0]), .addr(addr[0]),
    .wdata(wdata[0]),
`ifdef MEM_RESP_BYTEEN_EN
    .be(be[0]),
`endif
    .rdata(rdata[0]), .ready(ready[0]), .err(err[0]));

  mem_responder #(.ADDR_W(8), .WAIT_STATES(0)) u1 (
    .clock(clock), .reset(reset), .req(req[1]), .wr(wr[1]), .addr(addr[1]),
    .wdata(wdata[1]),
`ifdef MEM_RESP_BYTEEN_EN
    .be(be[1]),
`endif
    .rdata(rdata[1]), .ready(ready[1]), .err(err[1]));

  mem_responder #(.ADDR_W(8), .WAIT_STATES(4)) u2 (
    .clock(clock), .reset(reset), .req(req[2]), .wr(wr[2]), .addr(addr[2]),
    .wdata(wdata[2]),
`ifdef MEM_RESP_BYTEEN_EN
    .be(be[2]),
`endif
    .rdata(rdata[2]), .ready(ready[2]), .err(err[2]));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One request on unit u; the unit must be idle. Latency counts negedges
  // after the acceptance edge until ready is seen (WAIT_STATES+1 expected).
  task automatic txn(input int u, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] b, input int ws,
                     input logic exp_err, input logic chk_rd,
                     input logic [31:0] exp_rd, input string nm);
    int lat;
    @(negedge clock);
    req[u] = 1'b1; wr[u] = w; addr[u] = a; wdata[u] = d; be[u] = b;
    @(negedge clock);
    req[u] = 1'b0;
    lat = 1;
    while (ready[u] !== 1'b1 && lat <= 40) begin
      @(negedge clock);
      lat++;
    end
    check({nm, " latency"}, 32'(lat), 32'(ws + 1));
    check({nm, " err"}, {31'd0, err[u]}, {31'd0, exp_err});
    if (chk_rd) check({nm, " rdata"}, rdata[u], exp_rd);
    @(negedge clock);
    check({nm, " ready width"}, {31'd0, ready[u]}, 32'd0);
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic        e;
    logic        c;
    logic [31:0] r;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic seen;
    tbl[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 32'h10,       32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 32'h0,        32'h11111111, 1'b0, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 32'h12,       32'hBAD0BAD0, 1'b1, 1'b1, 32'h0};
    tbl[4]  = '{1'b1, 32'h400,      32'hBAD1BAD1, 1'b1, 1'b1, 32'h0};
    tbl[5]  = '{1'b0, 32'h10,       32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
    tbl[6]  = '{1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 32'h11111111};
    tbl[7]  = '{1'b0, 32'h13,       32'h0,        1'b1, 1'b1, 32'h0};
    tbl[8]  = '{1'b1, 32'h3FC,      32'h55AA55AA, 1'b0, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 32'h3FC,      32'h0,        1'b0, 1'b1, 32'h55AA55AA};
    tbl[10] = '{1'b0, 32'h80000000, 32'h0,        1'b1, 1'b1, 32'h0};
    tbl[11] = '{1'b0, 32'h3FC,      32'h0,        1'b0, 1'b1, 32'h55AA55AA};

    // Reset held with requests pending.
    reset = 1'b0;
    req   = 3'b111;
    wr    = 3'b000;
    for (int u = 0; u < 3; u++) begin
      addr[u] = 32'h10; wdata[u] = 32'h0; be[u] = 4'hF;
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      for (int u = 0; u < 3; u++) begin
        check($sformatf("reset ready u%0d c%0d", u, c), {31'd0, ready[u]}, 32'd0);
        check($sformatf("reset err u%0d c%0d", u, c), {31'd0, err[u]}, 32'd0);
        check($sformatf("reset rdata u%0d c%0d", u, c), rdata[u], 32'd0);
      end
    end
    req   = 3'b000;
    reset = 1'b1;
    @(negedge clock);
    check("post-reset idle ready", {29'd0, ready}, 32'd0);

    // Main function, WAIT_STATES=2.
    for (int i = 0; i < 12; i++) begin
      txn(0, tbl[i].w, tbl[i].a, tbl[i].d, 4'hF, 2, tbl[i].e, tbl[i].c, tbl[i].r,
          $sformatf("vec%0d", i));
    end

`ifdef MEM_RESP_BYTEEN_EN
    txn(0, 1'b1, 32'h30, 32'hAABBCCDD, 4'hF,    2, 1'b0, 1'b0, 32'h0, "be full");
    txn(0, 1'b1, 32'h30, 32'h11223344, 4'b0101, 2, 1'b0, 1'b0, 32'h0, "be 0101");
    txn(0, 1'b0, 32'h30, 32'h0,        4'h0,    2, 1'b0, 1'b1, 32'hAA22CC44, "be rd1");
    txn(0, 1'b1, 32'h30, 32'hFFFFFFFF, 4'h0,    2, 1'b0, 1'b0, 32'h0, "be none");
    txn(0, 1'b0, 32'h30, 32'h0,        4'hF,    2, 1'b0, 1'b1, 32'hAA22CC44, "be rd2");
`endif

    // WAIT_STATES=0, req held high across two reads.
    txn(1, 1'b1, 32'h0, 32'h01010101, 4'hF, 0, 1'b0, 1'b0, 32'h0, "ws0 w0");
    txn(1, 1'b1, 32'h4, 32'h02020202, 4'hF, 0, 1'b0, 1'b0, 32'h0, "ws0 w4");
    @(negedge clock);
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h0;
    @(negedge clock);
    check("b2b ready c1", {31'd0, ready[1]}, 32'd1);
    check("b2b rdata c1", rdata[1], 32'h01010101);
    addr[1] = 32'h4;
    @(negedge clock);
    check("b2b ready c2", {31'd0, ready[1]}, 32'd0);
    @(negedge clock);
    check("b2b ready c3", {31'd0, ready[1]}, 32'd1);
    check("b2b rdata c3", rdata[1], 32'h02020202);
    req[1] = 1'b0;
    @(negedge clock);
    check("b2b ready c4", {31'd0, ready[1]}, 32'd0);

    // Reset in the second WAIT cycle of a WAIT_STATES=4 write.
    txn(2, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 4, 1'b0, 1'b0, 32'h0, "ws4 prior");
    @(negedge clock);
    req[2] = 1'b1; wr[2] = 1'b1; addr[2] = 32'h20; wdata[2] = 32'h12345678;
    @(negedge clock);
    req[2] = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check("abort rdata reset", rdata[2], 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (ready[2]) seen = 1'b1;
    end
    check("abort no ready", {31'd0, seen}, 32'd0);
    txn(2, 1'b0, 32'h20, 32'h0, 4'hF, 4, 1'b0, 1'b1, 32'hCAFEF00D, "abort readback");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
